// File: rtl/banked_data_memory.sv
// -----------------------------------------------------------------------------
// banked_data_memory
//
// Byte-addressed data memory for the load/store path. Storage is split into
// NB = DATA_W/8 byte-wide banks, one per lane. A request is captured with a
// req/ack handshake. Optional wait states come before the first beat. An
// unaligned access is split into two beats: the tail of word w, then the head
// of word w+1. The word index wraps to 0 at the top of memory.
//
// Parameters
//   DATA_W       data width in bits; a multiple of 8. NB must be a power of two
//                and at least 2.
//   ADDR_W       byte address width; total storage is 2**ADDR_W bytes.
//   WAIT_STATES  extra cycles before the first beat of every access (0..15).
//
// Optional feature
//   MEM_PARITY_EN  When defined, one even-parity bit is stored per byte. The
//                  bit is inverted when par_inj was captured with the write.
//                  A read reports any mismatch on par_err together with ack.
//                  When undefined, par_err is tied to 0 and par_inj is unused.
//
// Ports
//   clock     in   single clock, all logic on the rising edge
//   reset     in   synchronous, active-high
//   req       in   access request; sampled only while not busy
//   we        in   1 = write, 0 = read (captured with req)
//   addr      in   byte address of lane 0 (captured with req)
//   be        in   byte enables for writes; be[k] selects byte addr+k
//   wdata     in   write data; byte k goes to addr+k (little-endian)
//   hold_sel  in   1: rmdata shows the previous completed read
//   par_inj   in   invert stored parity on this write (parity builds only)
//   busy      out  transaction in progress; req is ignored
//   ack       out  one-cycle completion pulse
//   rdata     out  data of the last completed read
//   rmdata    out  hold_sel ? previous read data : rdata
//   par_err   out  parity error on the acked read (valid with ack)
// -----------------------------------------------------------------------------
module banked_data_memory #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                hold_sel,
  input  logic                par_inj,
  output logic                busy,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   rmdata,
  output logic                par_err
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int WW = ADDR_W - OW;
  localparam int WD = 2 ** WW;
  localparam logic [WW-1:0] WORD_ONE  = WW'(1);
  localparam logic [3:0]    WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BEAT1 = 3'd2,
    S_BEAT2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              accept;

  // Request captured at the accept edge
  logic              we_q;
  logic [OW-1:0]     off_q;
  logic [WW-1:0]     word_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wdata_q;

  // Read assembly and result registers
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_prev_q;

  // Byte banks; the array is not reset
  logic [7:0]        mem_q [NB][WD];

  // Per-beat lane view
  logic              beat_act;
  logic              last_beat;
  logic [WW-1:0]     beat_word;
  logic [NB-1:0]     lane_act;
  logic [OW-1:0]     lane_k [NB];
  logic [DATA_W-1:0] merged;

`ifdef MEM_PARITY_EN
  logic              inj_q;
  logic              par_q [NB][WD];
  logic              beat_err;
  logic              err_q;
  logic              par_err_q;
`else
  logic              unused_par_inj;
  assign unused_par_inj = par_inj;
`endif

  // A request is taken when idle, and also in the ack cycle (back-to-back).
  assign accept = req && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ack    = (state_q == S_DONE);
  assign rdata  = rdata_q;
  assign rmdata = hold_sel ? rdata_prev_q : rdata_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WCNT_INIT;
          end else begin
            state_d = S_BEAT1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = S_BEAT1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_BEAT1: state_d = (off_q == '0) ? S_DONE : S_BEAT2;
      S_BEAT2: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Lane k of a beat carries data byte (k - offset) mod NB. In BEAT1 the
  // lanes at or above the offset take part. In BEAT2 the lanes below it take
  // part, using the next word.
  always_comb begin
    beat_act  = (state_q == S_BEAT1) || (state_q == S_BEAT2);
    beat_word = (state_q == S_BEAT2) ? (word_q + WORD_ONE) : word_q;
    last_beat = (state_q == S_BEAT2) || ((state_q == S_BEAT1) && (off_q == '0));
    merged    = asm_q;
`ifdef MEM_PARITY_EN
    beat_err  = 1'b0;
`endif
    for (int l = 0; l < NB; l++) begin
      lane_k[l]   = OW'(l) - off_q;
      lane_act[l] = 1'b0;
      if (state_q == S_BEAT1) begin
        lane_act[l] = (OW'(l) >= off_q);
      end else if (state_q == S_BEAT2) begin
        lane_act[l] = (OW'(l) < off_q);
      end
      if (lane_act[l]) begin
        merged[{lane_k[l], 3'b000} +: 8] = mem_q[l][beat_word];
`ifdef MEM_PARITY_EN
        if (par_q[l][beat_word] != ^mem_q[l][beat_word]) begin
          beat_err = 1'b1;
        end
`endif
      end
    end
  end

  // Write commit: each beat edge writes its enabled lanes. Reset wins, so a
  // beat that coincides with reset is not written. BEAT1 bytes written
  // before a reset stay written.
  always_ff @(posedge clock) begin
    if (!reset && beat_act && we_q) begin
      for (int l = 0; l < NB; l++) begin
        if (lane_act[l] && be_q[lane_k[l]]) begin
          mem_q[l][beat_word] <= wdata_q[{lane_k[l], 3'b000} +: 8];
`ifdef MEM_PARITY_EN
          par_q[l][beat_word] <= (^wdata_q[{lane_k[l], 3'b000} +: 8]) ^ inj_q;
`endif
        end
      end
    end
  end

  // Capture stage: request fields at accept, partial read word per beat
  always_ff @(posedge clock) begin
    if (accept) begin
      we_q    <= we;
      off_q   <= addr[OW-1:0];
      word_q  <= addr[ADDR_W-1:OW];
      be_q    <= be;
      wdata_q <= wdata;
`ifdef MEM_PARITY_EN
      inj_q   <= par_inj;
`endif
    end
    if (beat_act && !we_q) begin
      asm_q <= merged;
    end
  end

  // Result stage: the final read beat updates rdata, so rdata is already
  // valid in the ack cycle. The old rdata moves to rdata_prev.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q      <= '0;
      rdata_prev_q <= '0;
    end else if (beat_act && !we_q && last_beat) begin
      rdata_q      <= merged;
      rdata_prev_q <= rdata_q;
    end
  end

`ifdef MEM_PARITY_EN
  // Parity errors are collected over both beats. The flag is driven only
  // in the ack cycle of a read.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= 1'b0;
      if (accept) begin
        err_q <= 1'b0;
      end else if (beat_act && !we_q) begin
        err_q <= err_q | beat_err;
        if (last_beat) begin
          par_err_q <= err_q | beat_err;
        end
      end
    end
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_banked_data_memory.sv
module tb_banked_data_memory;

`ifdef MEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, req2, we, hold_sel, par_inj;
  logic [15:0] addr, wdata;
  logic [1:0]  be;
  logic        busy, ack, par_err;
  logic [15:0] rdata, rmdata;
  logic        busy2, ack2, par_err2;
  logic [15:0] unused_rd2, unused_rm2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  bit hs_auto = 1;

  always #5 clk = ~clk;

  banked_data_memory #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(0)) dut (
    .clock(clk), .reset(rst), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .hold_sel(hold_sel), .par_inj(par_inj), .busy(busy),
    .ack(ack), .rdata(rdata), .rmdata(rmdata), .par_err(par_err));

  banked_data_memory #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(3)) dut_ws3 (
    .clock(clk), .reset(rst), .req(req2), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .hold_sel(hold_sel), .par_inj(par_inj), .busy(busy2),
    .ack(ack2), .rdata(unused_rd2), .rmdata(unused_rm2), .par_err(par_err2));

  // ---------------- behavioural model of the WAIT_STATES=0 instance ----------
  logic [7:0]  mref  [65536];
  bit          mkn   [65536];
  bit          mpbad [65536];

  bit          m_pend = 0, m_ackw = 0;
  int          m_t, m_lat;
  bit          m_we, m_inj, m_unal, m_pacc;
  logic [15:0] m_addr, m_wd;
  logic [1:0]  m_be;
  logic [15:0] m_asm, m_rd, m_prev;
  logic [1:0]  m_asmk, m_rdk, m_prevk;
  bit          m_perr, m_perrk;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_m(input string nm, input logic [15:0] got, input logic [15:0] exp,
                       input logic [1:0] kn);
    logic [15:0] msk;
    msk = {{8{kn[1]}}, {8{kn[0]}}};
    if (kn != 2'b00) chk(nm, got & msk, exp & msk);
  endtask

  // Byte k of the access goes to address addr+k. It belongs to the first beat
  // while it stays inside word w, and to the second beat otherwise.
  task automatic m_beat(input int b);
    int o;
    logic [15:0] ba;
    o = int'(m_addr[0]);
    for (int k = 0; k < 2; k++) begin
      if ((k < 2 - o) == (b == 0)) begin
        ba = m_addr + 16'(k);
        if (m_we) begin
          if (m_be[k]) begin
            mref[ba] = m_wd[8*k +: 8];
            mkn[ba] = 1'b1;
            mpbad[ba] = m_inj;
          end
        end else begin
          m_asm[8*k +: 8] = mref[ba];
          m_asmk[k] = mkn[ba];
          if (mpbad[ba]) m_pacc = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_ackw = 0;
      m_rd = '0; m_rdk = 2'b11; m_prev = '0; m_prevk = 2'b11;
      m_perr = 0; m_perrk = 1;
    end else if (m_pend) begin
      m_t++;
      if (m_t == 1) m_beat(0);
      if (m_unal && m_t == 2) m_beat(1);
      if (m_t == m_lat - 1) begin
        m_pend = 0; m_ackw = 1;
        m_perr = 0; m_perrk = 1;
        if (!m_we) begin
          m_prev = m_rd; m_prevk = m_rdk;
          m_rd = m_asm; m_rdk = m_asmk;
          m_perr = PAR_ON && m_pacc;
          m_perrk = !PAR_ON || (m_asmk == 2'b11);
        end
      end
    end else begin
      m_ackw = 0;
      if (req) begin
        m_pend = 1; m_t = 0;
        m_we = we; m_addr = addr; m_be = be; m_wd = wdata; m_inj = par_inj;
        m_unal = addr[0]; m_lat = m_unal ? 3 : 2;
        m_asmk = 2'b00; m_pacc = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 16'(busy), 16'(m_pend));
      chk("ack", 16'(ack), 16'(m_ackw));
      chk_m("rdata", rdata, m_rd, m_rdk);
      if (hold_sel) chk_m("rmdata_hold", rmdata, m_prev, m_prevk);
      else          chk_m("rmdata_cur", rmdata, m_rd, m_rdk);
      if (!m_ackw)     chk("par_err_idle", 16'(par_err), 16'd0);
      else if (m_perrk) chk("par_err", 16'(par_err), 16'(m_perr));
    end
  end

  always @(posedge clk) begin
    #2;
    if (hs_auto) hold_sel = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic op(input bit w, input logic [15:0] a, input logic [1:0] b,
                    input logic [15:0] d, input bit inj, input int rst_after);
    int guard;
    guard = 0;
    @(negedge clk);
    while (m_pend && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) chk("op_start_timeout", 16'(guard), 16'd0);
    req = 1; we = w; addr = a; be = b; wdata = d; par_inj = inj;
    @(posedge clk);
    #1;
    req = 0;
    we = 1'($urandom); addr = 16'($urandom); be = 2'($urandom); wdata = 16'($urandom);
    par_inj = 1'($urandom);
    if (rst_after >= 0) begin
      repeat (rst_after) @(negedge clk);
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
    end
  endtask

  task automatic wait_ack(output int n, output bit busy_at_ack);
    n = 0; busy_at_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (ack) begin
        busy_at_ack = busy;
        return;
      end
    end
    n = -1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
    op(1'b1, a, b, d, 1'b0, -1);
  endtask

  task automatic rd(input logic [15:0] a);
    op(1'b0, a, 2'b00, 16'h0000, 1'b0, -1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, acks, lat;
    bit  bz;
    logic [15:0] a;
    rst = 1; req = 0; req2 = 0; we = 0; addr = '0; be = '0; wdata = '0;
    par_inj = 0; hold_sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_ack", 16'(ack), 16'd0);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_par_err", 16'(par_err), 16'd0);

    // Read of uninitialised address 0: latency 2, not busy in the ack cycle
    rd(16'h0000);
    wait_ack(n, bz);
    chk("rd0_latency", 16'(n), 16'd2);
    chk("rd0_busy_at_ack", 16'(bz), 16'd0);

    // Aligned write/read, partial byte enable, be=0 write
    wr(16'h0010, 16'h1234, 2'b11);
    rd(16'h0010); wait_ack(n, bz);
    chk("rd_1234", rdata, 16'h1234);
    wr(16'h0010, 16'hABCD, 2'b01);
    rd(16'h0010); wait_ack(n, bz);
    chk("rd_12CD", rdata, 16'h12CD);
    wr(16'h0010, 16'hDEAD, 2'b00);
    rd(16'h0010); wait_ack(n, bz);
    chk("be0_unchanged", rdata, 16'h12CD);

    // Unaligned write
    wr(16'h0021, 16'hBEEF, 2'b11);
    wait_ack(n, bz);
    chk("unal_wr_latency", 16'(n), 16'd3);
    rd(16'h0021); wait_ack(n, bz);
    chk("rd_BEEF", rdata, 16'hBEEF);
    rd(16'h0020); wait_ack(n, bz);
    chk("byte_0x21", rdata & 16'hFF00, 16'hEF00);
    rd(16'h0022); wait_ack(n, bz);
    chk("byte_0x22", rdata & 16'h00FF, 16'h00BE);

    // Wait states: ack 5 edges after accept; a held req is not re-accepted
    @(negedge clk);
    we = 0; addr = 16'h0010; req2 = 1;
    @(posedge clk);
    lat = -1; acks = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack2) begin
        acks++;
        if (lat < 0) begin
          lat = i;
          req2 = 0;
          chk("ws3_busy_at_ack", 16'(busy2), 16'd0);
          chk("ws3_par_err", 16'(par_err2), 16'd0);
        end
      end else if (lat < 0) begin
        chk("ws3_busy_waiting", 16'(busy2), 16'd1);
      end
    end
    chk("ws3_latency", 16'(lat), 16'd5);
    chk("ws3_ack_count", 16'(acks), 16'd1);
    chk("ws3_idle_after", 16'(busy2), 16'd0);

    // Hold-previous-read mux
    wr(16'h0030, 16'h1111, 2'b11);
    wr(16'h0032, 16'h2222, 2'b11);
    rd(16'h0030);
    rd(16'h0032); wait_ack(n, bz);
    hs_auto = 0;
    @(posedge clk); #1 hold_sel = 1;
    @(negedge clk);
    chk("rmdata_hold", rmdata, 16'h1111);
    @(posedge clk); #1 hold_sel = 0;
    @(negedge clk);
    chk("rmdata_cur", rmdata, 16'h2222);
    hs_auto = 1;

    // Top-of-memory wrap, then reset after the first beat
    wr(16'h0000, 16'h3344, 2'b11);
    wr(16'hFFFE, 16'h5566, 2'b11);
    wr(16'hFFFF, 16'hFFFF, 2'b11);
    rd(16'h0000); wait_ack(n, bz);
    chk("wrap_low", rdata, 16'h33FF);
    rd(16'hFFFE); wait_ack(n, bz);
    chk("wrap_high", rdata, 16'hFF66);
    op(1'b1, 16'hFFFF, 2'b11, 16'h7788, 1'b0, 1);
    chk("rst_mid_ack", 16'(ack), 16'd0);
    chk("rst_mid_busy", 16'(busy), 16'd0);
    rd(16'hFFFE); wait_ack(n, bz);
    chk("rst_mid_beat1_written", rdata, 16'h8866);
    rd(16'h0000); wait_ack(n, bz);
    chk("rst_mid_beat2_skipped", rdata, 16'h33FF);

`ifdef MEM_PARITY_EN
    op(1'b1, 16'h0040, 2'b11, 16'h00A5, 1'b1, -1);
    rd(16'h0040); wait_ack(n, bz);
    chk("par_inj_err", 16'(par_err), 16'd1);
    wr(16'h0040, 16'h00A5, 2'b11);
    rd(16'h0040); wait_ack(n, bz);
    chk("par_clean", 16'(par_err), 16'd0);
`endif

    // Randomised traffic, back-to-back, with occasional mid-op resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) a = 16'hFFF8 + 16'($urandom_range(0, 7));
      else                           a = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      op(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 16'($urandom),
         PAR_ON && ($urandom_range(0, 7) == 0),
         ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 2)) : -1);
    end
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
